// File: rtl/rgb_ddr_burst_writer.sv
// Packs FWFT RGB pixels into DATA_WIDTH-bit memory words and writes them to an MCB-style port,
// issuing one write command per BURST_LEN words, with an end-of-frame flush.
module rgb_ddr_burst_writer #(
  parameter int unsigned RGB_WIDTH  = 24,
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          PACKED     = 1'b1,
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned ADDR_WIDTH = 30
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    frame_start,
  input  logic [ADDR_WIDTH-1:0]   frame_base,
  input  logic                    flush,
  input  logic [RGB_WIDTH-1:0]    pix_data,
  input  logic                    pix_valid,
  output logic                    pix_read,
  output logic                    wr_en,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH/8-1:0] wr_mask,
  input  logic                    wr_full,
  output logic                    cmd_en,
  output logic [2:0]              cmd_instr,
  output logic [5:0]              cmd_bl,
  output logic [ADDR_WIDTH-1:0]   cmd_byte_addr,
  input  logic                    cmd_full,
  output logic                    flush_done,
  output logic                    busy,
  output logic                    seq_err
);

  localparam int unsigned PIX_W  = PACKED ? RGB_WIDTH : 32;
  localparam int unsigned ACC_W  = DATA_WIDTH + PIX_W;
  localparam int unsigned FILL_W = $clog2(ACC_W);
  localparam int unsigned WCNT_W = $clog2(BURST_LEN + 1);
  localparam int unsigned BYTES  = DATA_WIDTH / 8;

  localparam logic [FILL_W-1:0] FILL_DW  = FILL_W'(DATA_WIDTH);
  localparam logic [FILL_W-1:0] FILL_PIX = FILL_W'(PIX_W);
  localparam logic [WCNT_W-1:0] WCNT_BL  = WCNT_W'(BURST_LEN);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StCmd  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  flush_req_q, flush_req_d;
  logic                  seq_err_q, seq_err_d;
  logic                  flush_done_q, flush_done_d;
  logic [PIX_W-1:0]      pix_ext;
  logic [WCNT_W-1:0]     wcnt_m1;

  assign pix_ext = PIX_W'(pix_data);
  assign wcnt_m1 = wcnt_q - WCNT_W'(1);

  // Accept needs fill below a word, emit needs a full word, so they never coincide.
  always_comb begin
    pix_read = 1'b0;
    wr_en    = 1'b0;
    cmd_en   = 1'b0;
    if (state_q == StRun) begin
      pix_read = pix_valid && (fill_q < FILL_DW) && !flush_req_q;
      wr_en    = (fill_q >= FILL_DW) && !wr_full && (wcnt_q < WCNT_BL);
    end
    if (state_q == StCmd) begin
      cmd_en = !cmd_full;
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    fill_d       = fill_q;
    wcnt_d       = wcnt_q;
    addr_d       = addr_q;
    flush_req_d  = flush_req_q;
    seq_err_d    = seq_err_q;
    flush_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (frame_start) begin
          state_d     = StRun;
          addr_d      = frame_base;
          acc_d       = '0;
          fill_d      = '0;
          wcnt_d      = '0;
          flush_req_d = flush;
        end else if (flush) begin
          flush_done_d = 1'b1;
        end
      end
      StRun: begin
        if (frame_start) seq_err_d = 1'b1;
        if (flush) flush_req_d = 1'b1;
        if (pix_read) begin
          acc_d[fill_q +: PIX_W] = pix_ext;
          fill_d = fill_q + FILL_PIX;
        end else if (wr_en) begin
          acc_d  = acc_q >> DATA_WIDTH;
          fill_d = fill_q - FILL_DW;
          wcnt_d = wcnt_q + WCNT_W'(1);
        end else if (flush_req_q && (fill_q != '0) && (fill_q < FILL_DW)) begin
          // Upper acc bits are already zero, so this emits a zero-padded word.
          fill_d = FILL_DW;
        end
        if (wcnt_d == WCNT_BL) begin
          state_d = StCmd;
        end else if (flush_req_q && (fill_q == '0)) begin
          if (wcnt_q != '0) begin
            state_d = StCmd;
          end else begin
            state_d      = StIdle;
            flush_req_d  = 1'b0;
            flush_done_d = 1'b1;
          end
        end
      end
      StCmd: begin
        if (frame_start) seq_err_d = 1'b1;
        if (flush) flush_req_d = 1'b1;
        if (cmd_en) begin
          addr_d = addr_q + ADDR_WIDTH'(wcnt_q) * ADDR_WIDTH'(BYTES);
          wcnt_d = '0;
          if (flush_req_q && (fill_q == '0)) begin
            state_d      = StIdle;
            flush_req_d  = 1'b0;
            flush_done_d = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      fill_q       <= '0;
      wcnt_q       <= '0;
      addr_q       <= '0;
      flush_req_q  <= 1'b0;
      seq_err_q    <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      wcnt_q       <= wcnt_d;
      addr_q       <= addr_d;
      flush_req_q  <= flush_req_d;
      seq_err_q    <= seq_err_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign wr_data       = acc_q[DATA_WIDTH-1:0];
  assign wr_mask       = '0;
  assign cmd_instr     = 3'b000;
  assign cmd_bl        = (state_q == StCmd) ? 6'(wcnt_m1) : 6'd0;
  assign cmd_byte_addr = addr_q;
  assign busy          = (state_q != StIdle);
  assign flush_done    = flush_done_q;
  assign seq_err       = seq_err_q;

endmodule

// File: tb/tb_rgb_ddr_burst_writer.sv
// Bench for rgb_ddr_burst_writer: table-driven frames against a bit-stream reference model,
// plus hand-written backpressure, sequence-error and reset scenarios.
module tb_rgb_ddr_burst_writer;

  localparam int DW = 32;
  localparam int BL = 16;
  localparam int AW = 30;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          frame_start = 1'b0, flush = 1'b0, sel_u = 1'b0;
  logic [AW-1:0] frame_base = '0;
  logic          wr_full = 1'b0, cmd_full = 1'b0;
  logic [23:0]   pix_data;
  logic          pix_valid_p, pix_valid_u, pix_read_p, pix_read_u;
  logic          fs_p, fs_u, fl_p, fl_u;

  logic          wr_en_p, wr_en_u, cmd_en_p, cmd_en_u;
  logic [DW-1:0] wr_data_p, wr_data_u;
  logic [3:0]    wr_mask_p, wr_mask_u;
  logic [2:0]    cmd_instr_p, cmd_instr_u;
  logic [5:0]    cmd_bl_p, cmd_bl_u;
  logic [AW-1:0] cmd_addr_p, cmd_addr_u;
  logic          flush_done_p, flush_done_u, busy_p, busy_u, seq_err_p, seq_err_u;

  // Pixel source: array written by the stimulus, read pointer owned by the monitor.
  logic [23:0] pix_mem [0:511];
  logic [23:0] fixed_pix [4];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  bit          src_en = 1'b1, rand_gate = 1'b0, take;
  logic        have;

  assign have        = (rd_ptr != wr_ptr) && src_en;
  assign pix_data    = pix_mem[rd_ptr[8:0]];
  assign pix_valid_p = have && !sel_u;
  assign pix_valid_u = have && sel_u;
  assign fs_p        = frame_start && !sel_u;
  assign fs_u        = frame_start && sel_u;
  assign fl_p        = flush && !sel_u;
  assign fl_u        = flush && sel_u;

  rgb_ddr_burst_writer #(.RGB_WIDTH(24), .DATA_WIDTH(DW), .PACKED(1'b1), .BURST_LEN(BL),
                         .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst_n), .frame_start(fs_p), .frame_base(frame_base), .flush(fl_p),
    .pix_data(pix_data), .pix_valid(pix_valid_p), .pix_read(pix_read_p),
    .wr_en(wr_en_p), .wr_data(wr_data_p), .wr_mask(wr_mask_p), .wr_full(wr_full),
    .cmd_en(cmd_en_p), .cmd_instr(cmd_instr_p), .cmd_bl(cmd_bl_p), .cmd_byte_addr(cmd_addr_p),
    .cmd_full(cmd_full), .flush_done(flush_done_p), .busy(busy_p), .seq_err(seq_err_p)
  );

  rgb_ddr_burst_writer #(.RGB_WIDTH(24), .DATA_WIDTH(DW), .PACKED(1'b0), .BURST_LEN(BL),
                         .ADDR_WIDTH(AW)) dut_u (
    .clk(clk), .rst(rst_n), .frame_start(fs_u), .frame_base(frame_base), .flush(fl_u),
    .pix_data(pix_data), .pix_valid(pix_valid_u), .pix_read(pix_read_u),
    .wr_en(wr_en_u), .wr_data(wr_data_u), .wr_mask(wr_mask_u), .wr_full(wr_full),
    .cmd_en(cmd_en_u), .cmd_instr(cmd_instr_u), .cmd_bl(cmd_bl_u), .cmd_byte_addr(cmd_addr_u),
    .cmd_full(cmd_full), .flush_done(flush_done_u), .busy(busy_u), .seq_err(seq_err_u)
  );

  logic          pix_read_m, wr_en_m, cmd_en_m, flush_done_m, busy_m, seq_err_m;
  logic [DW-1:0] wr_data_m;
  logic [3:0]    wr_mask_m;
  logic [2:0]    cmd_instr_m;
  logic [5:0]    cmd_bl_m;
  logic [AW-1:0] cmd_addr_m;

  assign pix_read_m   = sel_u ? pix_read_u   : pix_read_p;
  assign wr_en_m      = sel_u ? wr_en_u      : wr_en_p;
  assign wr_data_m    = sel_u ? wr_data_u    : wr_data_p;
  assign wr_mask_m    = sel_u ? wr_mask_u    : wr_mask_p;
  assign cmd_en_m     = sel_u ? cmd_en_u     : cmd_en_p;
  assign cmd_instr_m  = sel_u ? cmd_instr_u  : cmd_instr_p;
  assign cmd_bl_m     = sel_u ? cmd_bl_u     : cmd_bl_p;
  assign cmd_addr_m   = sel_u ? cmd_addr_u   : cmd_addr_p;
  assign flush_done_m = sel_u ? flush_done_u : flush_done_p;
  assign busy_m       = sel_u ? busy_u       : busy_p;
  assign seq_err_m    = sel_u ? seq_err_u    : seq_err_p;

  // Monitor: logs pushes and commands on the falling edge, advances the source after the rise.
  logic [DW-1:0] wr_log [$];
  logic [AW-1:0] ca_log [$];
  logic [5:0]    cb_log [$];
  int            fd_cnt = 0;
  int            mon_viol = 0;

  always begin
    @(negedge clk);
    take = pix_read_m;
    if (wr_en_m) begin
      wr_log.push_back(wr_data_m);
      if (wr_full) mon_viol++;
    end
    if (cmd_en_m) begin
      ca_log.push_back(cmd_addr_m);
      cb_log.push_back(cmd_bl_m);
      if (cmd_full) mon_viol++;
    end
    if (flush_done_m) fd_cnt++;
    @(posedge clk);
    #1;
    if (take) rd_ptr++;
    src_en = rand_gate ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: pixels become a little-endian bit stream, cut into words (zero-padded at the
  // flush), then words are grouped into bursts at base + k*4.
  logic [DW-1:0] exp_w [$];
  logic [AW-1:0] exp_a [$];
  logic [5:0]    exp_b [$];

  task automatic build_model(input int p0, input int p1, input bit pk, input logic [AW-1:0] base);
    bit bq [$];
    logic [DW-1:0] w;
    int n;
    exp_w.delete();
    exp_a.delete();
    exp_b.delete();
    for (int i = p0; i < p1; i++) begin
      for (int b = 0; b < 24; b++) bq.push_back(pix_mem[i][b]);
      if (!pk) for (int b = 0; b < 8; b++) bq.push_back(1'b0);
    end
    while (bq.size() > 0) begin
      w = '0;
      for (int b = 0; b < DW; b++) if (bq.size() > 0) w[b] = bq.pop_front();
      exp_w.push_back(w);
    end
    n = exp_w.size();
    for (int k = 0; k < n; k += BL) begin
      exp_a.push_back(base + AW'(k * (DW / 8)));
      exp_b.push_back(6'((((n - k) < BL) ? (n - k) : BL) - 1));
    end
  endtask

  typedef struct {
    bit            unp;
    bit            simul;
    bit            rgate;
    bit            use_fixed;
    int            npix;
    logic [AW-1:0] base;
    int            exp_words;
    int            exp_cmds;
    int            exp_last_bl;
    logic [DW-1:0] exp_w0;
  } vec_t;

  vec_t vecs [7];

  task automatic run_vec(input vec_t v, input int idx);
    int w0, c0, f0, p0, v0;
    string tag;
    tag = $sformatf("v%0d", idx);
    w0 = wr_log.size();
    c0 = ca_log.size();
    f0 = fd_cnt;
    v0 = mon_viol;
    p0 = wr_ptr;
    sel_u = v.unp;
    rand_gate = v.rgate;
    for (int i = 0; i < v.npix; i++) begin
      pix_mem[wr_ptr[8:0]] = (v.use_fixed && i < 4) ? fixed_pix[i] : 24'($urandom);
      wr_ptr++;
    end
    frame_base = v.base;
    frame_start = 1'b1;
    flush = v.simul;
    step();
    frame_start = 1'b0;
    flush = 1'b0;
    for (int t = 0; t < 3000 && rd_ptr != wr_ptr; t++) step();
    chk({tag, "_consumed"}, rd_ptr == wr_ptr, 1);
    if (!v.simul) begin
      flush = 1'b1;
      step();
      flush = 1'b0;
    end
    for (int t = 0; t < 3000 && busy_m; t++) step();
    chk({tag, "_idle"}, busy_m, 0);
    repeat (3) step();
    build_model(p0, wr_ptr, !v.unp, v.base);
    chk({tag, "_nwords"}, wr_log.size() - w0, v.exp_words);
    chk({tag, "_nwords_model"}, wr_log.size() - w0, exp_w.size());
    for (int i = 0; i < exp_w.size() && w0 + i < wr_log.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), wr_log[w0 + i], exp_w[i]);
    if (v.use_fixed && wr_log.size() > w0) chk({tag, "_word0_ref"}, wr_log[w0], v.exp_w0);
    chk({tag, "_ncmds"}, ca_log.size() - c0, v.exp_cmds);
    chk({tag, "_ncmds_model"}, ca_log.size() - c0, exp_a.size());
    for (int i = 0; i < exp_a.size() && c0 + i < ca_log.size(); i++) begin
      chk($sformatf("%s_cmd%0d_addr", tag, i), ca_log[c0 + i], exp_a[i]);
      chk($sformatf("%s_cmd%0d_bl", tag, i), cb_log[c0 + i], exp_b[i]);
    end
    if (v.exp_cmds > 0 && ca_log.size() > c0)
      chk({tag, "_last_bl"}, cb_log[cb_log.size() - 1], v.exp_last_bl);
    chk({tag, "_flush_done_cnt"}, fd_cnt - f0, 1);
    chk({tag, "_no_push_while_full"}, mon_viol - v0, 0);
    chk({tag, "_mask_instr"}, {wr_mask_m, cmd_instr_m}, 0);
    rand_gate = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int w0, c0, f0, p0, v0, r_a, r_b, c1;
    fixed_pix[0] = 24'h112233;
    fixed_pix[1] = 24'h445566;
    fixed_pix[2] = 24'h778899;
    fixed_pix[3] = 24'hAABBCC;
    //          unp simul rgate fixed npix base          words cmds lastbl w0
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1,  4, 30'h100,       3,  1,  2, 32'h66112233};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 16, 30'h100,      16,  1, 15, 32'h00112233};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 64, 30'h100,      48,  3, 15, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0,  5, 30'h100,       4,  1,  3, 32'h0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0,  0, 30'h100,       0,  0,  0, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 43, 30'h3FFFFFC0, 33,  3,  0, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 20, 30'h40,       20,  2,  3, 32'h0};

    // Reset state
    #12;
    chk("reset_outputs_p", {wr_en_p, cmd_en_p, pix_read_p, flush_done_p, busy_p, seq_err_p}, 0);
    chk("reset_values_p", {wr_data_p, cmd_bl_p, cmd_addr_p, wr_mask_p, cmd_instr_p}, 0);
    chk("reset_busy_u", {busy_u, seq_err_u, wr_en_u, cmd_en_u}, 0);
    step();
    rst_n = 1'b1;
    repeat (2) step();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Backpressure: stalled run must produce exactly the model (unstalled) stream.
    sel_u = 1'b0;
    w0 = wr_log.size();
    c0 = ca_log.size();
    f0 = fd_cnt;
    v0 = mon_viol;
    p0 = wr_ptr;
    for (int i = 0; i < 64; i++) begin
      pix_mem[wr_ptr[8:0]] = 24'($urandom);
      wr_ptr++;
    end
    frame_base = 30'h1000;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int t = 0; t < 500 && rd_ptr - p0 < 20; t++) step();
    chk("bp_reach_mid", rd_ptr - p0 >= 20, 1);
    wr_full = 1'b1;
    r_a = 0;
    r_b = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 5) r_a = rd_ptr;
      if (i == 19) r_b = rd_ptr;
    end
    wr_full = 1'b0;
    chk("bp_pix_read_stall", r_b - r_a, 0);
    for (int t = 0; t < 500 && wr_log.size() - w0 < 32; t++) step();
    chk("bp_reach_burst2", wr_log.size() - w0 >= 32, 1);
    cmd_full = 1'b1;
    repeat (10) step();
    chk("bp_cmd_stall", ca_log.size() - c0, 1);
    cmd_full = 1'b0;
    for (int t = 0; t < 3000 && rd_ptr != wr_ptr; t++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int t = 0; t < 3000 && busy_m; t++) step();
    repeat (3) step();
    build_model(p0, wr_ptr, 1'b1, 30'h1000);
    chk("bp_nwords", wr_log.size() - w0, exp_w.size());
    for (int i = 0; i < exp_w.size() && w0 + i < wr_log.size(); i++)
      chk($sformatf("bp_word%0d", i), wr_log[w0 + i], exp_w[i]);
    chk("bp_ncmds", ca_log.size() - c0, exp_a.size());
    for (int i = 0; i < exp_a.size() && c0 + i < ca_log.size(); i++) begin
      chk($sformatf("bp_cmd%0d_addr", i), ca_log[c0 + i], exp_a[i]);
      chk($sformatf("bp_cmd%0d_bl", i), cb_log[c0 + i], exp_b[i]);
    end
    chk("bp_flush_done_cnt", fd_cnt - f0, 1);
    chk("bp_no_push_while_full", mon_viol - v0, 0);

    // Illegal frame_start in RUN, then reset mid-burst.
    w0 = wr_log.size();
    c0 = ca_log.size();
    for (int i = 0; i < 30; i++) begin
      pix_mem[wr_ptr[8:0]] = 24'($urandom);
      wr_ptr++;
    end
    frame_base = 30'h200;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    repeat (3) step();
    frame_base = 30'h3AB00;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    step();
    chk("seq_err_set", seq_err_p, 1);
    for (int t = 0; t < 2000 && ca_log.size() == c0; t++) step();
    chk("seq_cmd_seen", ca_log.size() > c0, 1);
    if (ca_log.size() > c0) chk("seq_addr_unchanged", ca_log[c0], 30'h200);
    for (int t = 0; t < 2000 && wr_log.size() - w0 < 20; t++) step();
    chk("rst_mid_burst_reached", wr_log.size() - w0 >= 20, 1);
    rst_n = 1'b0;
    #2;
    c1 = ca_log.size();
    chk("rst_outputs", {wr_en_p, cmd_en_p, pix_read_p, flush_done_p, busy_p, seq_err_p}, 0);
    chk("rst_values", {wr_data_p, cmd_bl_p, cmd_addr_p, wr_mask_p, cmd_instr_p}, 0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (30) step();
    chk("post_rst_no_cmd", ca_log.size() - c1, 0);
    chk("post_rst_idle", {busy_p, pix_read_p, seq_err_p, wr_en_p}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rgb_ddr_burst_writer.md
# rgb_ddr_burst_writer

Single-clock packer and burst writer between the pixel receive FIFO read side (DDR clock domain) and one MCB-style write port. It consumes first-word-fall-through RGB pixels, packs them (24-bit dense or 32-bit padded) into DATA_WIDTH-bit memory words, and writes them into the port's write-data FIFO. It issues one write command per BURST_LEN words at an auto-incrementing byte address, and supports an end-of-frame flush that emits a partial word and a partial burst.

## Interface
- RGB_WIDTH, 24: pixel width.
- DATA_WIDTH, 32: memory word width; 32, 64 or 128.
- PACKED, 1: 1 = dense packing, PIX_W = RGB_WIDTH; 0 = each pixel zero-extended to PIX_W = 32.
- BURST_LEN, 16: words per command; 1..64.
- ADDR_WIDTH, 30: byte address width.

Ports:
- clk  in  1  DDR-domain clock.
- rst  in  1  reset; asynchronous, active-low.
- frame_start  in  1  one-cycle pulse; starts a frame at frame_base.
- frame_base  in  ADDR_WIDTH  frame start byte address; sampled on an accepted frame_start.
- flush  in  1  one-cycle pulse; drains the partial word and partial burst.
- pix_data  in  RGB_WIDTH  FIFO head pixel (FWFT).
- pix_valid  in  1  FIFO not empty.
- pix_read  out  1  FIFO rd_en; the head pixel is consumed in the same cycle.
- wr_en  out  1  write-data FIFO push.
- wr_data  out  DATA_WIDTH  write word.
- wr_mask  out  DATA_WIDTH/8  byte mask; constant 0.
- wr_full  in  1  write-data FIFO full.
- cmd_en  out  1  command push.
- cmd_instr  out  3  constant 3'b000 (write).
- cmd_bl  out  6  burst length minus 1.
- cmd_byte_addr  out  ADDR_WIDTH  burst start address.
- cmd_full  in  1  command FIFO full.
- flush_done  out  1  one-cycle pulse when a flush completes.
- busy  out  1  state != IDLE.
- seq_err  out  1  sticky; set by an illegal frame_start.

## Operation
- The block has three states: IDLE, RUN and CMD.
- Registers:
  - acc: DATA_WIDTH+PIX_W bits.
  - fill: number of valid bits in acc, 0..DATA_WIDTH+PIX_W-1.
  - wcnt: words pushed since the last command, 0..BURST_LEN.
  - addr: ADDR_WIDTH bits.
  - flush_req: pending-flush flag.
- IDLE:
  - pix_read = 0.
  - frame_start: addr <= frame_base, acc/fill/wcnt cleared, go to RUN.
  - flush: flush_done pulses the next cycle; no memory traffic.
- RUN, pixel accept:
  - pix_read = pix_valid && fill < DATA_WIDTH && !flush_req.
  - On accept: acc[fill +: PIX_W] <= pixel (zero-extended when PACKED=0), and fill += PIX_W.
- RUN, word emit:
  - wr_en = fill >= DATA_WIDTH && !wr_full && wcnt < BURST_LEN.
  - wr_data = acc[DATA_WIDTH-1:0].
  - On emit: acc >>= DATA_WIDTH with zero fill, fill -= DATA_WIDTH, wcnt++.
- Accept and emit are mutually exclusive, because they are gated by fill on opposite sides of DATA_WIDTH.
- Packing is little-endian: the first pixel occupies the word LSBs, and pixels straddle word boundaries with no gaps.
- wcnt == BURST_LEN in RUN: go to CMD.
- CMD:
  - cmd_en = !cmd_full, with cmd_bl = wcnt-1 and cmd_byte_addr = addr.
  - On cmd_en: addr += wcnt*DATA_WIDTH/8 (modulo 2^ADDR_WIDTH), and wcnt <= 0.
  - Return to RUN, or to IDLE if the burst was a flush burst.
- flush in RUN or CMD:
  - flush_req <= 1 and pixel accept stops.
  - Once fill < DATA_WIDTH and fill > 0, set fill <= DATA_WIDTH. The upper bits are already zero, so the word is emitted zero-padded.
  - Once fill == 0:
    - wcnt > 0: go to CMD, then IDLE.
    - wcnt == 0: go to IDLE directly.
  - On entering IDLE: flush_done pulses and flush_req clears.
- frame_start outside IDLE is ignored and sets seq_err, which is cleared only by rst.
- wr_mask = 0 and cmd_instr = 3'b000 at all times.

## Timing
- pix_read, wr_en and cmd_en are combinational from registers plus pix_valid, wr_full and cmd_full. No push ever occurs while the corresponding full flag is high.
- Throughput: each pixel costs at most 2 cycles (one accept, plus at most one emit).
- The command for a full burst is issued at the earliest 1 cycle after its last word push.
- Reset (async assert):
  - State returns to IDLE and acc, fill, wcnt, addr, flush_req and seq_err clear.
  - Every output is 0 except cmd_bl, cmd_byte_addr and wr_data, which are 0 by value.
  - Partial data is discarded and no partial command is issued.
- Reset deassertion: the first active edge is the first clk edge after rst rises.
- Simultaneous frame_start and flush in IDLE: frame_start wins; the flush is latched and processed in RUN.
- Address wrap past 2^ADDR_WIDTH wraps silently.

## Test plan
- Packed mode, DATA_WIDTH=32:
  - Stimulus: frame_base=0x100, pixels 0x112233, 0x445566, 0x778899, 0xAABBCC.
  - Required: words 0x66112233, 0x88994455, 0xAABBCC77.
- PACKED=0:
  - Stimulus: pixel 0x112233.
  - Required: word 0x00112233; 16 pixels produce exactly one command, with bl=15 and addr=0x100.
- Burst addressing, packed, BURST_LEN=16:
  - Stimulus: 64 pixels.
  - Required: 48 words and 3 commands at 0x100, 0x140 and 0x180, each with bl=15.
- Flush, packed:
  - Stimulus: 5 pixels then flush.
  - Required: 4 words, the last with bits [31:24]=0; one command with bl=3; flush_done pulses once; busy=0 afterwards.
- Backpressure:
  - Stimulus: hold wr_full for 20 cycles mid-stream, then cmd_full for 10 cycles at a burst end.
  - Required: no push while full, pix_read stalls, and the output data sequence is identical to the unstalled run.
- Error and reset:
  - Stimulus: frame_start in RUN; then assert rst mid-burst.
  - Required: seq_err=1 and addr unchanged; after reset all outputs are 0, state is IDLE, and no command follows reset release.
